// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and start/done sequencer feeding a UART transmitter.
// Bytes are pushed at clock rate and released one per tx_start/tx_done handshake.
module uart_tx_fifo #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [0:0]        ST_IDLE = 1'b0;
  localparam logic [0:0]        ST_BUSY = 1'b1;
  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DBIT-1:0]   mem_q [0:(1<<ADDR_W)-1];

  logic [0:0]        state_q,    state_d;
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic              tx_start_q, tx_start_d;
  logic [DBIT-1:0]   tx_data_q,  tx_data_d;
  logic              overflow_q, overflow_d;
  logic              push, pop;

  // Fullness and emptiness come from pre-edge occupancy, so a pop never frees room for a same-cycle push.
  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);
  assign push  = wr && !full;
  assign pop   = (state_q == ST_IDLE) && !empty;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overflow_d = wr && full;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_data_d  = mem_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          tx_start_d = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      default: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= w_data;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, fill/overflow, ordering with a
// transmitter model, simultaneous push/pop, mid-frame reset and spurious tx_done.
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] w_data;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;

  int tests;
  int fails;

  uart_tx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .w_data   (w_data),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".tx_start"}, {31'd0, tx_start}, 32'd0);
    chk({tag, ".tx_data"},  {24'd0, tx_data},  32'd0);
    chk({tag, ".full"},     {31'd0, full},     32'd0);
    chk({tag, ".empty"},    {31'd0, empty},    32'd1);
    chk({tag, ".count"},    {27'd0, count},    32'd0);
    chk({tag, ".overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  // One tx_done pulse returns the FSM to IDLE; the following edge may pop.
  task automatic done_then_idle_edge();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
  endtask

  initial begin
    int starts;
    int since;
    int active;
    int done_edge;
    int exp_idx;
    logic [7:0] cur;

    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    wr      = 1'b0;
    w_data  = 8'h00;
    tx_done = 1'b0;

    // Reset
    #2 reset = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    reset = 1'b1;
    tick();
    chk_reset_vals("post_reset_idle");

    // Single byte
    wr = 1'b1; w_data = 8'hA5;
    tick();
    wr = 1'b0;
    chk("single.empty_after_push", {31'd0, empty},    32'd0);
    chk("single.count_after_push", {27'd0, count},    32'd1);
    chk("single.no_start_yet",     {31'd0, tx_start}, 32'd0);
    tick();
    chk("single.tx_start", {31'd0, tx_start}, 32'd1);
    chk("single.tx_data",  {24'd0, tx_data},  32'hA5);
    chk("single.count0",   {27'd0, count},    32'd0);
    starts = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_start) starts++;
    end
    chk("single.no_restart_busy", starts, 0);
    chk("single.data_held", {24'd0, tx_data}, 32'hA5);
    done_then_idle_edge();
    chk("single.empty_after_done", {31'd0, empty},    32'd1);
    chk("single.no_start_after",   {31'd0, tx_start}, 32'd0);

    // Fill and overflow
    for (int i = 0; i <= 16; i++) begin
      wr = 1'b1; w_data = 8'(i);
      tick();
      if (i == 1) begin
        chk("fill.first_start", {31'd0, tx_start}, 32'd1);
        chk("fill.first_data",  {24'd0, tx_data},  32'h00);
      end
    end
    chk("fill.full",  {31'd0, full},  32'd1);
    chk("fill.count", {27'd0, count}, 32'd16);
    chk("fill.no_ovf_yet", {31'd0, overflow}, 32'd0);
    w_data = 8'h11;
    tick();
    wr = 1'b0;
    chk("ovf.pulse", {31'd0, overflow}, 32'd1);
    chk("ovf.count", {27'd0, count},    32'd16);
    tick();
    chk("ovf.one_cycle", {31'd0, overflow}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      done_then_idle_edge();
      chk("drain.start", {31'd0, tx_start}, 32'd1);
      chk("drain.data",  {24'd0, tx_data},  32'(i));
    end
    done_then_idle_edge();
    chk("drain.empty",    {31'd0, empty},    32'd1);
    chk("drain.no_start", {31'd0, tx_start}, 32'd0);

    // Ordering with a transmitter returning tx_done 20 cycles after tx_start
    active = 0; since = 0; done_edge = -100; exp_idx = 0; cur = 8'h00;
    for (int c = 0; c < 400; c++) begin
      wr = (c < 16);
      w_data = 8'(c);
      if (active != 0) since++;
      tx_done = (active != 0) && (since == 20);
      if (tx_done) begin
        done_edge = c;
        active = 0;
      end
      tick();
      if (tx_start) begin
        chk("order.data", {24'd0, tx_data}, 32'(exp_idx));
        if (exp_idx > 0) chk("order.gap", c - done_edge, 1);
        if (active != 0) chk("order.start_while_busy", 1, 0);
        cur = tx_data;
        exp_idx++;
        active = 1;
        since = 0;
      end else if (active != 0 && tx_data !== cur) begin
        chk("order.data_stable", {24'd0, tx_data}, {24'd0, cur});
      end
    end
    wr = 1'b0; tx_done = 1'b0;
    chk("order.byte_count", exp_idx, 16);
    chk("order.empty", {31'd0, empty}, 32'd1);

    // Simultaneous push and pop
    wr = 1'b1; w_data = 8'hB0;
    tick();
    wr = 1'b0;
    tick();
    chk("simul.busy_start", {24'd0, tx_data}, 32'hB0);
    for (int i = 1; i <= 3; i++) begin
      wr = 1'b1; w_data = 8'h30 + 8'(i);
      tick();
    end
    wr = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("simul.count3_idle", {27'd0, count}, 32'd3);
    wr = 1'b1; w_data = 8'h3C;
    tick();
    wr = 1'b0;
    chk("simul.count_held", {27'd0, count},    32'd3);
    chk("simul.start",      {31'd0, tx_start}, 32'd1);
    chk("simul.data31",     {24'd0, tx_data},  32'h31);
    done_then_idle_edge();
    chk("simul.data32", {24'd0, tx_data}, 32'h32);
    done_then_idle_edge();
    chk("simul.data33", {24'd0, tx_data}, 32'h33);
    done_then_idle_edge();
    chk("simul.data3C_last", {24'd0, tx_data}, 32'h3C);
    chk("simul.empty_end",   {31'd0, empty},   32'd1);
    done_then_idle_edge();
    chk("simul.no_extra", {31'd0, tx_start}, 32'd0);

    // Reset mid-operation
    wr = 1'b1; w_data = 8'h50;
    tick();
    wr = 1'b0;
    tick();
    chk("rst.busy_data", {24'd0, tx_data}, 32'h50);
    for (int i = 1; i <= 5; i++) begin
      wr = 1'b1; w_data = 8'h50 + 8'(i);
      tick();
    end
    wr = 1'b0;
    chk("rst.count5", {27'd0, count}, 32'd5);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals("rst.async");
    #1 reset = 1'b1;
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx_start) starts++;
    end
    chk("rst.no_start_after", starts, 0);
    chk("rst.empty_after",    {31'd0, empty}, 32'd1);
    wr = 1'b1; w_data = 8'h77;
    tick();
    wr = 1'b0;
    tick();
    chk("rst.start77", {31'd0, tx_start}, 32'd1);
    chk("rst.data77",  {24'd0, tx_data},  32'h77);
    done_then_idle_edge();

    // Spurious tx_done in IDLE
    for (int i = 0; i < 3; i++) begin
      done_then_idle_edge();
      chk("spur.no_start", {31'd0, tx_start}, 32'd0);
      chk("spur.count",    {27'd0, count},    32'd0);
      chk("spur.empty",    {31'd0, empty},    32'd1);
    end
    wr = 1'b1; w_data = 8'h5A;
    tick();
    wr = 1'b0;
    chk("spur.no_early_start", {31'd0, tx_start}, 32'd0);
    tick();
    chk("spur.start", {31'd0, tx_start}, 32'd1);
    chk("spur.data",  {24'd0, tx_data},  32'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit buffer and handshake sequencer placed directly upstream of the UART transmitter. Producers (debug unit, processor memory dump) push bytes at full clock rate; the block stores them in a circular FIFO and releases them one at a time to the transmitter. For each byte it issues a single-cycle `tx_start` with stable data, then waits for the transmitter's `tx_done` before releasing the next byte.

## Interface
- `DBIT`, default 8: data width in bits; must match the transmitter's `DBIT`.
- `ADDR_W`, default 4: FIFO address width; depth = 2^ADDR_W (16 entries).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr`  in  1  push request; sampled on the rising edge.
- `w_data`  in  DBIT  byte to push when `wr` is accepted.
- `tx_done`  in  1  transmitter end-of-frame pulse, one cycle.
- `tx_start`  out  1  registered one-cycle start pulse to the transmitter.
- `tx_data`  out  DBIT  registered byte to the transmitter; stable from `tx_start` until `tx_done`.
- `full`  out  1  FIFO holds 2^ADDR_W entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  ADDR_W+1  current occupancy, 0..2^ADDR_W.
- `overflow`  out  1  registered one-cycle pulse when a push is rejected.

## Operation
- Storage: 2^ADDR_W x DBIT register array with ADDR_W-bit write/read pointers.
  - Pointers wrap modulo 2^ADDR_W.
  - `count` is tracked explicitly; `full` = (count == 2^ADDR_W), `empty` = (count == 0), both decoded from registered `count`.
- Push: accepted iff `wr` && !`full` at the edge.
  - Writes `w_data` at the write pointer and increments the pointer.
  - `wr` && `full` drops the data, leaves pointers and `count` unchanged, and sets `overflow` = 1 for the next cycle.
  - A pop in the same cycle does not make room. Fullness is judged on pre-edge state.
- Pop: occurs only from state IDLE with !`empty`.
  - Loads `tx_data` <= mem[rd_ptr], increments the read pointer, and sets `tx_start` = 1.
- Simultaneous accepted push and pop: `count` is unchanged and both pointers advance.
- FSM, 2 states:
  - IDLE: if !`empty`, pop, `tx_start` <= 1, go to BUSY. Otherwise stay, with `tx_start` <= 0.
  - BUSY: `tx_start` <= 0. On `tx_done` go to IDLE; otherwise stay. `tx_data` holds.
- `tx_done` received in IDLE is ignored.
- FIFO order is strict: bytes leave in push order with no loss, except rejected pushes.
- Reset (asynchronous, `reset` = 0):
  - State IDLE, pointers 0, `count` 0.
  - `tx_start` 0, `tx_data` 0, `overflow` 0, so `empty` = 1 and `full` = 0.
  - Array contents are not cleared.
  - A frame already in flight in the transmitter is not aborted by this block.
  - After reset is released, nothing is sent until a new push.

## Timing
- Reset values: `tx_start` 0, `tx_data` 0, `full` 0, `empty` 1, `count` 0, `overflow` 0.
- Push-to-start latency, empty FIFO and IDLE:
  - Push accepted at edge E0 gives `empty` = 0 after E0.
  - Pop occurs at E1, so `tx_start` = 1 and `tx_data` are valid during the cycle after E1.
  - `count` returns to 0 after E1.
- `tx_start` is high for exactly one cycle per byte and is never reasserted while in BUSY.
- Back-to-back bytes: `tx_done` high in the cycle before edge T moves the FSM to IDLE at T. The next pop happens at T+1, so `tx_start` is high after T+1.
  - This gap of at least one cycle guarantees the transmitter has returned to its idle state before the next start.
- `overflow` asserts the cycle after the rejected edge, for one cycle per rejected push.
- `count`, `full` and `empty` reflect the result of the most recent edge.

## Test plan
- Single byte: reset, then push 0xA5 once. Require `tx_start` high for one cycle exactly 2 edges after the push, with `tx_data` = 0xA5. Hold `tx_done` = 0 for 50 cycles and require no further `tx_start`. Pulse `tx_done` and require `empty` = 1 and no new start.
- Fill and overflow: with `tx_done` held low, push 0x00..0x10 on consecutive cycles.
  - The first byte is popped, so 0x01..0x10 fill 16 entries and `full` = 1, `count` = 16.
  - A push of 0x11 gives an `overflow` pulse and `count` stays 16.
- Ordering: the transmitter model returns `tx_done` 20 cycles after each `tx_start`. Push 0x00..0x0F in a burst. Require `tx_data` sequence 0x00..0x0F with exactly one `tx_start` per byte and each `tx_start` at least 2 cycles after the previous `tx_done`.
- Simultaneous push/pop: with FIFO holding 3 bytes, in IDLE, push 0x3C in the pop cycle. Require `count` stays 3 and 0x3C emerges last.
- Reset mid-operation: with 5 bytes queued and the FSM in BUSY, assert `reset` low for a partial cycle. Require all outputs at reset values immediately, no `tx_start` after release, and the next pushed byte (0x77) sent normally.
- Spurious `tx_done`: in IDLE with an empty FIFO, pulse `tx_done` 3 times. Require no state change, no `tx_start`, and `count` = 0.
